// File: rtl/seletor_menor_custo.sv
// Per-iteration minimum-cost selector: scans the cost and established-flag memories,
// picks the cheapest non-established node with finite cost and marks it established.
module seletor_menor_custo #(
    parameter int ADDR_WIDTH = 8,
    parameter int COST_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    output logic                  cost_rd_en_out,
    output logic [ADDR_WIDTH-1:0] cost_addr_out,
    input  logic [COST_WIDTH-1:0] cost_data_in,
    output logic                  est_rd_en_out,
    output logic [ADDR_WIDTH-1:0] est_addr_out,
    input  logic                  est_data_in,
    output logic                  est_wr_en_out,
    output logic [ADDR_WIDTH-1:0] est_wr_addr_out,
    output logic                  est_wr_data_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  found_out,
    output logic [ADDR_WIDTH-1:0] node_out,
    output logic [COST_WIDTH-1:0] cost_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_MARK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_best_valid;
    logic [ADDR_WIDTH-1:0] r_best_node;
    logic [COST_WIDTH-1:0] r_best_cost;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_found;
    logic [ADDR_WIDTH-1:0] r_node;
    logic [COST_WIDTH-1:0] r_cost;

    logic w_cand;
    logic w_better;

    // Strict compare keeps the earlier (lower) address on equal costs.
    assign w_cand   = (r_state == S_SCAN) && !est_data_in && (cost_data_in != '1);
    assign w_better = w_cand && (!r_best_valid || (cost_data_in < r_best_cost));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_best_valid <= 1'b0;
            r_best_node  <= '0;
            r_best_cost  <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_node       <= '0;
            r_cost       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_state      <= S_SCAN;
                        r_cnt        <= '0;
                        r_best_valid <= 1'b0;
                        r_rd_en      <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_better) begin
                        r_best_valid <= 1'b1;
                        r_best_node  <= r_cnt;
                        r_best_cost  <= cost_data_in;
                    end
                    // Write strobe is registered here, so fold in the last entry's outcome.
                    if (r_cnt == LAST_ADDR) begin
                        r_state   <= S_MARK;
                        r_rd_en   <= 1'b0;
                        r_wr_en   <= r_best_valid | w_cand;
                        r_wr_addr <= w_better ? r_cnt : r_best_node;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MARK: begin
                    r_state <= S_DONE;
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b1;
                    r_found <= r_best_valid;
                    r_node  <= r_best_valid ? r_best_node : '0;
                    r_cost  <= r_best_valid ? r_best_cost : '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cost_rd_en_out  = r_rd_en;
    assign est_rd_en_out   = r_rd_en;
    assign cost_addr_out   = r_cnt;
    assign est_addr_out    = r_cnt;
    assign est_wr_en_out   = r_wr_en;
    assign est_wr_addr_out = r_wr_addr;
    assign est_wr_data_out = r_wr_en;
    assign busy_out        = r_busy;
    assign done_out        = r_done;
    assign found_out       = r_found;
    assign node_out        = r_node;
    assign cost_out        = r_cost;

endmodule

// File: tb/tb_seletor_menor_custo.sv
// Scoreboard bench for seletor_menor_custo (N=8, 8-bit costs) with combinational memory models.
module tb_seletor_menor_custo;

    localparam int AW = 3;
    localparam int CW = 8;
    localparam int N  = 8;

    typedef logic [CW-1:0] cost_arr_t [N];
    typedef logic          flag_arr_t [N];

    typedef struct {
        logic          found;
        logic [AW-1:0] node;
        logic [CW-1:0] cost;
        int            start_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_in;
    logic          cost_rd_en_out;
    logic [AW-1:0] cost_addr_out;
    logic [CW-1:0] cost_data_in;
    logic          est_rd_en_out;
    logic [AW-1:0] est_addr_out;
    logic          est_data_in;
    logic          est_wr_en_out;
    logic [AW-1:0] est_wr_addr_out;
    logic          est_wr_data_out;
    logic          busy_out;
    logic          done_out;
    logic          found_out;
    logic [AW-1:0] node_out;
    logic [CW-1:0] cost_out;

    cost_arr_t cost_mem;
    flag_arr_t flag_mem;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   done_cnt  = 0;
    int   wr_total  = 0;
    int   run_wr    = 0;
    logic [AW-1:0] last_wr = '0;

    seletor_menor_custo #(.ADDR_WIDTH(AW), .COST_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in),
        .cost_rd_en_out(cost_rd_en_out), .cost_addr_out(cost_addr_out), .cost_data_in(cost_data_in),
        .est_rd_en_out(est_rd_en_out), .est_addr_out(est_addr_out), .est_data_in(est_data_in),
        .est_wr_en_out(est_wr_en_out), .est_wr_addr_out(est_wr_addr_out), .est_wr_data_out(est_wr_data_out),
        .busy_out(busy_out), .done_out(done_out), .found_out(found_out),
        .node_out(node_out), .cost_out(cost_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational-read memories; the flag memory accepts the selector's writes.
    assign cost_data_in = cost_mem[cost_addr_out];
    assign est_data_in  = flag_mem[est_addr_out];

    always @(posedge clk) begin
        if (est_wr_en_out) flag_mem[est_wr_addr_out] <= 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: minimum finite cost among non-established nodes, lowest address on ties.
    function automatic exp_t ref_select(input cost_arr_t c, input flag_arr_t f);
        exp_t e;
        int best = 256;
        e.found = 1'b0; e.node = '0; e.cost = '0; e.start_cyc = 0;
        for (int i = 0; i < N; i++)
            if (!f[i] && c[i] != 8'hFF && int'(c[i]) < best) best = int'(c[i]);
        if (best < 256) begin
            e.found = 1'b1;
            e.cost  = best[CW-1:0];
            for (int i = N - 1; i >= 0; i--)
                if (!f[i] && int'(c[i]) == best) e.node = i[AW-1:0];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            run_wr = 0;
        end else begin
            if (est_wr_en_out) begin
                run_wr++;
                wr_total++;
                last_wr = est_wr_addr_out;
                check("wr_data", int'(est_wr_data_out), 1);
            end
            if (done_out) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done pulse expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("found", int'(found_out), int'(e.found));
                    check("node", int'(node_out), int'(e.node));
                    check("cost", int'(cost_out), int'(e.cost));
                    check("latency", cyc - e.start_cyc, N + 1);
                    check("busy_at_done", int'(busy_out), 1);
                    check("write_count", run_wr, e.found ? 1 : 0);
                    if (e.found) check("write_addr", int'(last_wr), int'(e.node));
                end
                run_wr = 0;
            end
        end
    end

    function automatic int outs_vec();
        return int'({busy_out, done_out, found_out, node_out, cost_out, est_wr_en_out,
                     est_wr_data_out, cost_rd_en_out, est_rd_en_out, cost_addr_out,
                     est_addr_out, est_wr_addr_out});
    endfunction

    task automatic wait_drain(input int limit);
        int t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_one();
        exp_t e;
        e = ref_select(cost_mem, flag_mem);
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_drain(4 * N);
    endtask

    task automatic load(input cost_arr_t c, input flag_arr_t f);
        cost_mem = c;
        flag_mem = f;
    endtask

    initial begin
        cost_arr_t c;
        flag_arr_t f;
        flag_arr_t zf;
        int saved_wr;
        int saved_done;
        int exp_done;

        for (int i = 0; i < N; i++) zf[i] = 1'b0;
        exp_done = 0;
        start_in = 1'b0;
        rst_n    = 1'b0;
        load('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, zf);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_vec(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie between nodes 2 and 4
        load('{8'hFF, 8'h07, 8'h03, 8'h09, 8'h03, 8'hFF, 8'hFF, 8'hFF}, zf);
        run_one(); exp_done++;
        check("flag2_set", int'(flag_mem[2]), 1);
        f = zf; f[2] = 1'b1;
        load('{8'hFF, 8'h07, 8'h03, 8'h09, 8'h03, 8'hFF, 8'hFF, 8'hFF}, f);
        run_one(); exp_done++;
        load('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, zf);
        run_one(); exp_done++;
        for (int i = 0; i < N; i++) f[i] = 1'b1;
        load('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, f);
        run_one(); exp_done++;
        load('{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, zf);
        run_one(); exp_done++;
        load('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, zf);
        run_one(); exp_done++;

        // Randomised runs with frequent ties, infinities and near-infinite costs
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)      c[i] = 8'hFF;
                else if ($urandom_range(0, 4) == 0) c[i] = 8'hFE;
                else                                c[i] = 8'($urandom_range(0, 20));
                f[i] = ($urandom_range(0, 3) == 0);
            end
            load(c, f);
            run_one(); exp_done++;
        end

        // Back-to-back with start held high; each run sees the previous run's flag write
        for (int i = 0; i < N; i++) c[i] = 8'($urandom_range(0, 254));
        load(c, zf);
        begin
            flag_arr_t fm;
            exp_t e;
            int base;
            fm = zf;
            base = cyc + 1;
            for (int k = 0; k < 10; k++) begin
                e = ref_select(c, fm);
                e.start_cyc = base + k * (N + 3);
                if (e.found) fm[e.node] = 1'b1;
                sb.push_back(e);
            end
            start_in = 1'b1;
            wait_drain(12 * (N + 3));
            start_in = 1'b0;
            exp_done += 10;
        end
        repeat (2) @(posedge clk); #1;

        // Reset during the fifth scan cycle drops the run and any pending write
        load('{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h06, 8'h07}, zf);
        saved_wr   = wr_total;
        saved_done = done_cnt;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs", outs_vec(), 0);
        check("midscan_reset_busy", int'(busy_out), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("no_write_after_reset", wr_total, saved_wr);
        check("no_done_after_reset", done_cnt, saved_done);
        check("flags_untouched", int'({flag_mem[0], flag_mem[1], flag_mem[2], flag_mem[3],
                                       flag_mem[4], flag_mem[5], flag_mem[6], flag_mem[7]}), 0);
        run_one(); exp_done++;

        // Start pulsed mid-scan must be ignored
        load('{8'h10, 8'h20, 8'hFF, 8'h08, 8'h30, 8'hFF, 8'h08, 8'h40}, zf);
        begin
            exp_t e;
            e = ref_select(cost_mem, flag_mem);
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_drain(4 * N);
        exp_done++;
        repeat (20) @(posedge clk);
        #1;
        check("done_pulse_count", done_cnt, exp_done);
        check("idle_busy", int'(busy_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
